// File: rtl/rv_pkg.sv
// Shared types for the RVTU commit watcher.
//   commitRec_t  : one retired-instruction record as stored in the trace FIFO
//                  and presented on the trace port.
//   watchState_t : commit watcher control states.
//   REC_W        : packed width of commitRec_t.
//   mask_rd_data : zeroes write data for instructions without a destination.
package rv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] isn;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
  } commitRec_t;

  localparam int REC_W = $bits(commitRec_t);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } watchState_t;

  // x0 is never written, so its data is reported as zero.
  function automatic logic [31:0] mask_rd_data(input logic [4:0]  rd,
                                               input logic [31:0] data);
    return (rd == 5'd0) ? 32'd0 : data;
  endfunction

endpackage

// File: rtl/rvtu_commit_fifo.sv
// Registered-storage FIFO holding commit records for the trace sink.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties FIFO, clears storage)
//   push       : write request; accepted when not full, or full with a pop this cycle
//   push_data  : record to write
//   full       : DEPTH entries held
//   pop        : read request; honoured only when not empty
//   empty      : no entries held
//   head       : oldest entry (valid when !empty)
module rvtu_commit_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_en;
  logic          push_en;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop_en  = pop && (count != {CW{1'b0}});
  assign push_en = push && ((count != CW'(DEPTH)) || pop_en);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvtu_commit_watch.sv
// Commit-stream watcher for the RVTU harness: buffers retired-instruction
// records for a ready/valid trace sink, counts commits, detects program end
// (a self-loop jump retiring HALT_REPEAT times in a row) and flags a hung core.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cm_valid                 : commit record valid (cannot be stalled)
//   cm_pc_rdata/cm_pc_wdata  : PC of retiring instruction / next PC
//   cm_isn, cm_rd, cm_rd_wdata : instruction word, destination, write data
//   tr_valid/tr_ready        : trace FIFO head handshake
//   tr_pc, tr_isn, tr_rd, tr_rd_wdata : trace head record
//   halt                     : program finished (or timed out) and FIFO drained
//   err_wdog                 : sticky watchdog timeout
//   err_ovf                  : sticky record-dropped flag
//   commit_cnt               : records accepted since reset
module rvtu_commit_watch
  import rv_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WDOG_CYCLES = 100000,
  parameter int HALT_REPEAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc_rdata,
  input  logic [31:0] cm_pc_wdata,
  input  logic [31:0] cm_isn,
  input  logic [4:0]  cm_rd,
  input  logic [31:0] cm_rd_wdata,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_isn,
  output logic [4:0]  tr_rd,
  output logic [31:0] tr_rd_wdata,
  output logic        halt,
  output logic        err_wdog,
  output logic        err_ovf,
  output logic [63:0] commit_cnt
);

  localparam int LW = $clog2(HALT_REPEAT + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  watchState_t state;
  watchState_t state_next;
  logic [LW-1:0] loop_cnt;
  logic [WW-1:0] wdog_cnt;
  commitRec_t    rec_in;
  commitRec_t    rec_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          self_loop;
  logic          halt_commit;
  logic          timeout;
  logic          pop;
  logic          overflow;

  assign accept      = cm_valid && (state == RUN);
  assign self_loop   = (cm_pc_wdata == cm_pc_rdata);
  assign halt_commit = accept && self_loop && (loop_cnt == LW'(HALT_REPEAT - 1));
  // Timeout can only fire on an idle cycle, so a halt commit on the terminal
  // cycle naturally takes precedence.
  assign timeout     = (state == RUN) && !cm_valid && (wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign pop         = !fifo_empty && tr_ready;
  assign overflow    = accept && fifo_full && !pop;

  // Record as stored: rd data zeroed when there is no destination register.
  always_comb begin
    rec_in          = '0;
    rec_in.pc       = cm_pc_rdata;
    rec_in.isn      = cm_isn;
    rec_in.rd       = cm_rd;
    rec_in.rd_wdata = mask_rd_data(cm_rd, cm_rd_wdata);
  end

  rvtu_commit_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (rec_in),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (rec_head)
  );

  assign tr_valid    = !fifo_empty;
  assign tr_pc       = rec_head.pc;
  assign tr_isn      = rec_head.isn;
  assign tr_rd       = rec_head.rd;
  assign tr_rd_wdata = rec_head.rd_wdata;

  // Watcher state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN until halt commit or timeout, DRAIN until FIFO empty.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (halt_commit) begin
          state_next = DRAIN;
        end else if (timeout) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = HALTED;
        end else begin
          state_next = DRAIN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Commit, self-loop and idle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt <= 64'd0;
      loop_cnt   <= {LW{1'b0}};
      wdog_cnt   <= {WW{1'b0}};
    end else begin
      if (accept) begin
        commit_cnt <= commit_cnt + 64'd1;
        loop_cnt   <= self_loop ? (loop_cnt + LW'(1)) : {LW{1'b0}};
      end
      if (cm_valid) begin
        wdog_cnt <= {WW{1'b0}};
      end else if (state == RUN) begin
        wdog_cnt <= wdog_cnt + WW'(1);
      end
    end
  end

  // Sticky error flags and registered halt indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_wdog <= 1'b0;
      err_ovf  <= 1'b0;
      halt     <= 1'b0;
    end else begin
      if (timeout && !halt_commit) begin
        err_wdog <= 1'b1;
      end
      if (overflow) begin
        err_ovf <= 1'b1;
      end
      halt <= (state_next == HALTED);
    end
  end

endmodule

// File: tb/tb_rvtu_commit_watch.sv
// Self-checking bench for rvtu_commit_watch: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_rvtu_commit_watch;

  localparam int DEPTH = 8;
  localparam int WDOG  = 16;
  localparam int HREP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cm_valid = 1'b0;
  logic [31:0] cm_pc_rdata = 32'd0;
  logic [31:0] cm_pc_wdata = 32'd0;
  logic [31:0] cm_isn = 32'd0;
  logic [4:0]  cm_rd = 5'd0;
  logic [31:0] cm_rd_wdata = 32'd0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [31:0] tr_pc;
  logic [31:0] tr_isn;
  logic [4:0]  tr_rd;
  logic [31:0] tr_rd_wdata;
  logic        halt;
  logic        err_wdog;
  logic        err_ovf;
  logic [63:0] commit_cnt;

  rvtu_commit_watch #(
    .DEPTH       (DEPTH),
    .WDOG_CYCLES (WDOG),
    .HALT_REPEAT (HREP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cm_valid    (cm_valid),
    .cm_pc_rdata (cm_pc_rdata),
    .cm_pc_wdata (cm_pc_wdata),
    .cm_isn      (cm_isn),
    .cm_rd       (cm_rd),
    .cm_rd_wdata (cm_rd_wdata),
    .tr_valid    (tr_valid),
    .tr_ready    (tr_ready),
    .tr_pc       (tr_pc),
    .tr_isn      (tr_isn),
    .tr_rd       (tr_rd),
    .tr_rd_wdata (tr_rd_wdata),
    .halt        (halt),
    .err_wdog    (err_wdog),
    .err_ovf     (err_ovf),
    .commit_cnt  (commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] isn;
    logic [4:0]  rd;
    logic [31:0] wd;
  } rec_t;

  // Reference model state: queue of visible records, plain counters.
  rec_t        m_q[$];
  logic [63:0] m_cnt = 64'd0;
  int          m_loop = 0;
  int          m_idle = 0;
  int          m_phase = 0;   // 0 running, 1 draining, 2 halted
  bit          m_halt = 1'b0;
  bit          m_wdog = 1'b0;
  bit          m_ovf = 1'b0;
  bit          live = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int dut_pops = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_update();
    int   old_phase;
    int   old_size;
    bit   do_pop;
    rec_t r;
    if (rst) begin
      m_q.delete();
      m_cnt = 64'd0; m_loop = 0; m_idle = 0; m_phase = 0;
      m_halt = 1'b0; m_wdog = 1'b0; m_ovf = 1'b0;
      live = 1'b1;
    end else begin
      old_phase = m_phase;
      old_size  = m_q.size();
      do_pop    = (old_size > 0) && tr_ready;
      if (old_phase == 0) begin
        if (cm_valid) begin
          m_cnt  = m_cnt + 64'd1;
          m_idle = 0;
          m_loop = (cm_pc_wdata == cm_pc_rdata) ? m_loop + 1 : 0;
          r.pc  = cm_pc_rdata;
          r.isn = cm_isn;
          r.rd  = cm_rd;
          r.wd  = (cm_rd == 5'd0) ? 32'd0 : cm_rd_wdata;
          if (old_size == DEPTH && !do_pop) m_ovf = 1'b1;
          else m_q.push_back(r);
          if (m_loop == HREP) m_phase = 1;
        end else begin
          m_idle++;
          if (m_idle == WDOG) begin
            m_wdog  = 1'b1;
            m_phase = 1;
          end
        end
      end else if (old_phase == 1 && old_size == 0) begin
        m_phase = 2;
        m_halt  = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("tr_valid", 64'(tr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("tr_pc", 64'(tr_pc), 64'(m_q[0].pc));
        chk("tr_isn", 64'(tr_isn), 64'(m_q[0].isn));
        chk("tr_rd", 64'(tr_rd), 64'(m_q[0].rd));
        chk("tr_rd_wdata", 64'(tr_rd_wdata), 64'(m_q[0].wd));
      end
      chk("halt", 64'(halt), 64'(m_halt));
      chk("err_wdog", 64'(err_wdog), 64'(m_wdog));
      chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("commit_cnt", commit_cnt, m_cnt);
      if (tr_valid && tr_ready) dut_pops++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cm_valid = 1'b0;
    tr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pcr, input logic [31:0] pcw,
                        input logic [4:0] rd, input logic [31:0] wd);
    cm_valid    = 1'b1;
    cm_pc_rdata = pcr;
    cm_pc_wdata = pcw;
    cm_isn      = pcr ^ 32'h0000_0013;
    cm_rd       = rd;
    cm_rd_wdata = wd;
    step();
    cm_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    cm_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [31:0] pc;

    // Reset state
    do_reset();
    chk("rst tr_valid", 64'(tr_valid), 64'd0);
    chk("rst commit_cnt", commit_cnt, 64'd0);
    chk("rst halt", 64'(halt), 64'd0);

    // Basic flow: 5 commits streamed straight through
    tr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h4000_0000 + 32'(4 * i);
      cm_valid = 1'b1;
      cm_pc_rdata = pc; cm_pc_wdata = pc + 32'd4;
      cm_isn = 32'h0000_0093 + 32'(i); cm_rd = 5'd1; cm_rd_wdata = 32'(i);
      step();
    end
    idle(3);
    chk("basic commit_cnt", commit_cnt, 64'd5);
    chk("basic halt", 64'(halt), 64'd0);
    chk("basic drained", 64'(tr_valid), 64'd0);

    // Halt: two self-loop commits, third commit ignored
    do_reset();
    tr_ready = 1'b1;
    cm_valid = 1'b1;
    cm_pc_rdata = 32'h4000_0020; cm_pc_wdata = 32'h4000_0020;
    cm_isn = 32'h0000_006f; cm_rd = 5'd0; cm_rd_wdata = 32'd0;
    step(); step(); step();
    cm_valid = 1'b0;
    chk("halt not yet", 64'(halt), 64'd0);
    step();
    chk("halt asserted", 64'(halt), 64'd1);
    chk("halt commit_cnt", commit_cnt, 64'd2);
    idle(2);

    // Overflow: 11 commits into a stalled sink
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      commit(32'h0000_1000 + 32'(4 * i), 32'h0000_1004 + 32'(4 * i), 5'd2, 32'h100 + 32'(i));
    end
    chk("ovf err_ovf", 64'(err_ovf), 64'd1);
    chk("ovf commit_cnt", commit_cnt, 64'd11);
    chk("ovf head pc", 64'(tr_pc), 64'h1000);
    tr_ready = 1'b1;
    dut_pops = 0;
    idle(10);
    chk("ovf drained count", 64'(dut_pops), 64'd8);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      commit(32'h0000_2000 + 32'(4 * i), 32'h0000_2004 + 32'(4 * i), 5'd3, 32'(i));
    end
    tr_ready = 1'b1;
    commit(32'h0000_2020, 32'h0000_2024, 5'd3, 32'd8);
    tr_ready = 1'b0;
    chk("full pp err_ovf", 64'(err_ovf), 64'd0);
    chk("full pp commit_cnt", commit_cnt, 64'd9);
    chk("full pp head pc", 64'(tr_pc), 64'h2004);
    tr_ready = 1'b1;
    dut_pops = 0;
    idle(10);
    chk("full pp occupancy", 64'(dut_pops), 64'd8);

    // Watchdog timeout after 16 idle cycles
    do_reset();
    tr_ready = 1'b1;
    commit(32'h0000_3000, 32'h0000_3004, 5'd1, 32'd1);
    idle(WDOG - 1);
    chk("wdog before", 64'(err_wdog), 64'd0);
    idle(1);
    chk("wdog fired", 64'(err_wdog), 64'd1);
    idle(2);
    chk("wdog halt", 64'(halt), 64'd1);

    // Halt commit lands on the watchdog terminal cycle
    do_reset();
    tr_ready = 1'b1;
    commit(32'h0000_0100, 32'h0000_0100, 5'd0, 32'd0);
    idle(WDOG - 1);
    commit(32'h0000_0100, 32'h0000_0100, 5'd0, 32'd0);
    idle(4);
    chk("wdog race err_wdog", 64'(err_wdog), 64'd0);
    chk("wdog race halt", 64'(halt), 64'd1);

    // rd = 0 masking, then reset with entries queued
    do_reset();
    commit(32'h0000_4000, 32'h0000_4004, 5'd0, 32'hDEAD_BEEF);
    chk("rd0 tr_valid", 64'(tr_valid), 64'd1);
    chk("rd0 tr_rd_wdata", 64'(tr_rd_wdata), 64'd0);
    commit(32'h0000_4004, 32'h0000_4008, 5'd5, 32'hDEAD_BEEF);
    commit(32'h0000_4008, 32'h0000_400c, 5'd6, 32'h1234_5678);
    chk("pre-rst commit_cnt", commit_cnt, 64'd3);
    rst = 1'b1;
    step();
    chk("mid rst tr_valid", 64'(tr_valid), 64'd0);
    chk("mid rst commit_cnt", commit_cnt, 64'd0);
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvtu_commit_watch.md
Name: rvtu_commit_watch

Overview:
- Downstream consumer of the RVTU harness commit stream; takes one retired-instruction record per cycle.
- Buffers records in a small FIFO for a ready/valid trace sink (log writer or scoreboard).
- Counts commits and detects program end: a self-loop jump retiring HALT_REPEAT times in a row.
- Watchdog flags a hung core when nothing commits for WDOG_CYCLES cycles.

Parameters:
- DEPTH, 8, trace FIFO entries; power of two, at least 2.
- WDOG_CYCLES, 100000, idle cycles without a commit before timeout; at least 1.
- HALT_REPEAT, 2, consecutive self-loop commits (pc_wdata == pc_rdata) that declare halt; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cm_valid  in  1  commit record valid; cannot be stalled
- cm_pc_rdata  in  32  PC of retiring instruction
- cm_pc_wdata  in  32  next PC
- cm_isn  in  32  instruction word
- cm_rd  in  5  destination register, 0 if none
- cm_rd_wdata  in  32  destination write data
- tr_valid  out  1  FIFO head valid
- tr_ready  in  1  sink accepts head
- tr_pc  out  32  head PC
- tr_isn  out  32  head instruction
- tr_rd  out  5  head rd
- tr_rd_wdata  out  32  head rd data; 0 when tr_rd == 0
- halt  out  1  program finished (or timed out) and FIFO drained
- err_wdog  out  1  sticky watchdog timeout
- err_ovf  out  1  sticky: a record was dropped
- commit_cnt  out  64  records accepted since reset

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in RUN; all counters 0.
- Reset mid-operation discards FIFO contents; no partial state survives.
- FIFO, push side:
  - Push when cm_valid and FSM is RUN.
  - Stored rd_wdata is forced to 0 when cm_rd == 0.
  - Full and no pop in the same cycle: record dropped, err_ovf set, commit_cnt still increments.
- FIFO, pop side:
  - Pop when tr_valid && tr_ready.
  - Full with pop and push in the same cycle: both happen, occupancy unchanged.
  - Push into empty: tr_valid rises the next cycle (registered storage, 1-cycle latency).
  - Read/write pointers wrap modulo DEPTH; occupancy counter has log2(DEPTH)+1 bits.
- tr_* data is stable while tr_valid && !tr_ready.
- commit_cnt increments on each cm_valid accepted in RUN. It wraps at 2^64 and does not saturate.
- Self-loop counter (loop_cnt):
  - Valid commit with pc_wdata == pc_rdata: loop_cnt increments.
  - Any other valid commit: loop_cnt clears to 0.
  - Idle cycles leave loop_cnt unchanged.
- Watchdog counter:
  - Clears on each valid commit; otherwise increments while in RUN.
  - Reaching WDOG_CYCLES-1 on an idle cycle triggers timeout.
- FSM states:
  - RUN: a commit that takes loop_cnt to HALT_REPEAT is pushed, then go to DRAIN. A timeout sets err_wdog and goes to DRAIN.
  - DRAIN: ignore cm_valid (no push, no count). When FIFO is empty, go to HALTED.
  - HALTED: halt = 1. Stays until rst.
- Simultaneous halt-triggering commit and watchdog terminal count: the commit wins, so err_wdog stays 0.
- halt is registered; it asserts the cycle after the FIFO becomes empty in DRAIN.

Decomposition:
- Shared package (rv_pkg): commitRec_t packed struct {pc, isn, rd, rd_wdata} used by FIFO storage and the trace port; watchState_t enum {RUN, DRAIN, HALTED}.
- Sub-module rvtu_commit_fifo:
  - Parameterised by DEPTH and the commitRec_t width.
  - Ports: push, full, pop, empty, head.
  - Top level holds the FSM, counters and error flags.

Test Plan:
- Basic flow: 5 commits (pc 0x40000000..0x40000010 step 4, rd=1, data=i), tr_ready=1 → 5 trace records in order, each 1 cycle after its push; commit_cnt=5; halt=0.
- Halt: commits at 0x40000020 with pc_wdata=0x40000020, twice, tr_ready=1 → DRAIN, then halt=1 one cycle after FIFO empty; a third commit is not counted (commit_cnt stays 2).
- Overflow: tr_ready=0, DEPTH+3 = 11 back-to-back commits → 8 stored, err_ovf=1, commit_cnt=11; raise tr_ready → exactly the first 8 records drain.
- Full push+pop: FIFO full, tr_ready=1 and cm_valid=1 in the same cycle → no drop, occupancy stays 8, err_ovf=0.
- Watchdog: WDOG_CYCLES=16, 1 commit then idle → err_wdog=1 at 16 idle cycles; halt follows after drain. Variant: halt commit on the terminal cycle → err_wdog=0.
- rd=0 masking and reset: commit rd=0 with data 0xDEADBEEF → tr_rd_wdata=0. Assert rst with 3 entries queued → tr_valid=0 and commit_cnt=0 next cycle.
